// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO-side types and round-robin search helper
package fifo_pkg;

    // Write arbiter control states
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest request vector the round-robin search supports
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    // First set bit of req searching upward from ptr+1, wrapping modulo num_req.
    // Returns -1 when no bit is set. Iterating from the farthest candidate down
    // to the nearest lets the closest set bit overwrite the result without a break.
    function automatic int rr_next_idx(input logic [RR_MAX_REQ-1:0] req,
                                       input int num_req,
                                       input int ptr);
        int idx;
        int res;
        res = -1;
        for (int k = num_req; k >= 1; k--) begin
            idx = (ptr + k) % num_req;
            if (req[idx[RR_IDX_W-1:0]]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin first-set-bit picker
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [RR_MAX_REQ-1:0] req_ext;
    int                    pick;

    // Widen the request vector and search from the bit after ptr
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_next_idx(req_ext, NUM_REQ, int'(ptr));
        found                  = (pick >= 0);
        idx                    = found ? IDX_W'(pick) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic             gv_q, gv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic                  cur_valid;
    logic                  cur_last;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Route the granted producer's handshake and word
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gid_q == IDX_W'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state, grant bookkeeping and FIFO/producer handshake outputs
    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        gv_d         = gv_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        req_ready    = '0;
        xfer         = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_cs      = 1'b0;
        fifo_data_in = cur_data;
        case (state_q)
            IDLE: begin
                // Arbitration bubble: pick the next producer, no transfer here
                if (pick_found) begin
                    gid_d   = pick_idx;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (gid_q == IDX_W'(i)) && !fifo_full;
                end
                xfer       = cur_valid && !fifo_full;
                fifo_wr_en = xfer;
                fifo_cs    = xfer;
                // Release on end of packet, full burst, or an idle producer;
                // a full FIFO simply stalls with the grant held
                if ((xfer && (cur_last || cnt_q == CNT_W'(MAX_BURST - 1))) || !cur_valid) begin
                    state_d = IDLE;
                    ptr_d   = gid_q;
                    gv_d    = 1'b0;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gv_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and grant registers; pointer resets so producer 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gid_q   <= '0;
            gv_q    <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            gv_q    <= gv_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_valid = gv_q;
    assign grant_id    = gid_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_cs;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data_in;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_cs      (fifo_cs),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Producer word queues: {last, data}
    logic [DW:0]   pq[NR][$];
    logic [DW-1:0] sent[NR][$];
    logic [DW-1:0] rcvd[NR][$];
    bit            hold[NR];
    int            valid_pct;
    int            full_pct;
    bit            rst_at_third;

    // Reference: who owns the port, words moved this grant, last producer released
    int m_owner;
    int m_cnt;
    int m_last;

    int gseq[$];
    bit gv_prev;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = NR - 1;
        gv_prev = 1'b0;
        for (int i = 0; i < NR; i++) hold[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wr_en"}, fifo_wr_en, 0);
        check_val({tag, "_cs"}, fifo_cs, 0);
        check_val({tag, "_ready"}, req_ready, 0);
        check_val({tag, "_gv"}, grant_valid, 0);
        check_val({tag, "_gid"}, grant_id, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        #1;
        check_reset_outputs("reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_word(input int p, input logic [DW-1:0] d, input bit lst);
        pq[p].push_back({lst, d});
        sent[p].push_back(d);
    endtask

    // One clock: drive producers, check DUT against the reference, advance the reference
    task automatic step();
        bit exp_wr;
        bit lst;
        logic [NR-1:0] exp_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (pq[i].size() == 0) begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*DW +: DW] = $urandom;
            end else begin
                if (!hold[i] && $urandom_range(99) < valid_pct) hold[i] = 1'b1;
                req_valid[i]         = hold[i];
                req_last[i]          = pq[i][0][DW];
                req_data[i*DW +: DW] = pq[i][0][DW-1:0];
            end
        end
        fifo_full = ($urandom_range(99) < full_pct);
        #1;
        if (rst_at_third && m_owner >= 0 && m_cnt == 2 && req_valid[m_owner] && !fifo_full) begin
            check_val("pre_reset_wr_en", fifo_wr_en, 1);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_burst_reset");
            rst_at_third = 1'b0;
            for (int i = 0; i < NR; i++) pq[i].delete();
            req_valid = '0;
            model_reset();
            return;
        end
        #2;
        if (grant_valid && !gv_prev) gseq.push_back(int'(grant_id));
        gv_prev = grant_valid;
        if (fifo_wr_en) rcvd[grant_id].push_back(fifo_data_in);

        check_val("grant_valid", grant_valid, (m_owner >= 0));
        if (m_owner >= 0) begin
            exp_ready = '0;
            if (!fifo_full) exp_ready[m_owner] = 1'b1;
            exp_wr = req_valid[m_owner] && !fifo_full;
            check_val("grant_id", grant_id, m_owner);
            check_val("req_ready", req_ready, exp_ready);
            check_val("fifo_wr_en", fifo_wr_en, exp_wr);
            check_val("fifo_cs", fifo_cs, exp_wr);
            if (exp_wr) begin
                check_val("fifo_data_in", fifo_data_in, pq[m_owner][0][DW-1:0]);
                lst = pq[m_owner][0][DW];
                void'(pq[m_owner].pop_front());
                hold[m_owner] = 1'b0;
                m_cnt++;
                if (lst || m_cnt == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (!req_valid[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else begin
            check_val("idle_ready", req_ready, 0);
            check_val("idle_wr_en", fifo_wr_en, 0);
            check_val("idle_cs", fifo_cs, 0);
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (req_valid[c]) begin
                    m_owner = c;
                    m_cnt   = 0;
                    break;
                end
            end
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (m_owner >= 0);
        for (int i = 0; i < NR; i++) if (pq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        check_val({tag, "_drained"}, busy(), 0);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NR; i++) begin
            sent[i].delete();
            rcvd[i].delete();
        end
        gseq.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        fifo_full    = 1'b0;
        rst_at_third = 1'b0;
        model_reset();

        // Single producer 2, three words ending in last
        do_reset();
        clear_logs();
        valid_pct = 100;
        full_pct  = 0;
        for (int n = 0; n < 3; n++) push_word(2, 32'hB000_0000 + n, (n == 2));
        drain("single", 50);
        check_val("single_grants", gseq.size(), 1);
        if (gseq.size() > 0) check_val("single_gid", gseq[0], 2);
        check_val("single_words", rcvd[2].size(), 3);

        // All four continuously valid, no last: bursts of MAX_BURST in rr order
        do_reset();
        clear_logs();
        for (int i = 0; i < NR; i++)
            for (int n = 0; n < 8; n++) push_word(i, 32'hC000_0000 + i * 16 + n, 1'b0);
        drain("rr", 200);
        check_val("rr_grants", gseq.size(), 8);
        for (int k = 0; k < 5 && k < gseq.size(); k++) check_val("rr_order", gseq[k], k % NR);

        // Randomized traffic with tagged words, gaps, lasts and back-pressure
        do_reset();
        clear_logs();
        valid_pct = 60;
        full_pct  = 25;
        for (int i = 0; i < NR; i++) begin
            int nw;
            nw = 6 + $urandom_range(9);
            for (int n = 0; n < nw; n++)
                push_word(i, 32'hA000_0000 + i * 16 + n, (n == nw - 1) || ($urandom_range(3) == 0));
        end
        drain("rand", 3000);
        for (int i = 0; i < NR; i++) begin
            check_val("sb_count", rcvd[i].size(), sent[i].size());
            for (int n = 0; n < sent[i].size() && n < rcvd[i].size(); n++)
                if (rcvd[i][n] !== sent[i][n]) check_val("sb_word", rcvd[i][n], sent[i][n]);
        end

        // Reset while the third word of a burst is on the port
        do_reset();
        clear_logs();
        valid_pct = 100;
        full_pct  = 0;
        for (int n = 0; n < 6; n++) push_word(1, 32'hD000_0000 + n, 1'b0);
        rst_at_third = 1'b1;
        begin
            int c;
            c = 0;
            while (rst_at_third && c < 50) begin
                step();
                c++;
            end
        end
        check_val("reset_hit", rst_at_third, 0);
        check_val("reset_words_written", rcvd[1].size(), 2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        push_word(2, 32'hE000_0002, 1'b1);
        push_word(0, 32'hE000_0000, 1'b1);
        drain("post_reset", 50);
        check_val("post_reset_grants", gseq.size(), 2);
        if (gseq.size() > 1) begin
            check_val("post_reset_first", gseq[0], 0);
            check_val("post_reset_second", gseq[1], 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst and drives the FIFO's cs/wr_en/data_in.
- It honours the FIFO's full flag; it sits directly in front of the FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesting producers (>=2).
- DATA_WIDTH, 32, word width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum words accepted per grant before re-arbitration (>=1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-producer word valid.
- req_last  input  NUM_REQ  per-producer end-of-packet marker, qualified by valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer accept; one-hot or zero.
- fifo_full  input  1  full flag from the FIFO.
- fifo_cs  output  1  FIFO chip select.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  word to the FIFO.
- grant_valid  output  1  a grant is currently held.
- grant_id  output  $clog2(NUM_REQ)  index of the granted producer.

Behaviour:
- Reset values: state=IDLE, grant_valid=0, grant_id=0, burst count=0, rr pointer=NUM_REQ-1 (so producer 0 has first priority), req_ready=0, fifo_wr_en=0, fifo_cs=0.
- fifo_data_in is don't-care while fifo_wr_en=0; it is driven as the granted producer's word.
- State IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr pointer+1, wrapping modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, clear burst count, move to GRANT next cycle.
  - No transfer occurs in IDLE, so each grant costs one arbitration bubble cycle.
- State GRANT, with g=grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = fifo_cs = req_valid[g] & !fifo_full (combinational). fifo_data_in = req_data[g].
  - A transfer occurs when fifo_wr_en=1; burst count increments on each transfer.
- Release from GRANT to IDLE. The grant is released at the clock edge when any of these holds:
  - A transfer occurs with req_last[g]=1.
  - A transfer occurs with burst count==MAX_BURST-1.
  - req_valid[g]=0 (producer went idle; no transfer that cycle).
- On release: rr pointer<=g, grant_valid<=0, burst count<=0.
- fifo_full while granted: stall with no transfer. The grant and count are held and there is no timeout. A word held with valid=1 must stay stable (producer contract).
- Fairness: after releasing producer g, every other requesting producer is served before g is served again.
- A producer raising valid in the same cycle another is released competes in the next IDLE cycle.
- Wrap-around: the rr search wraps; with rr pointer=NUM_REQ-1 the search order is 0,1,…,NUM_REQ-1.
- Reset mid-burst: outputs drop to their reset values immediately (asynchronous). A word presented that cycle is not written. FIFO contents are the FIFO's concern.
- Burst count width is $clog2(MAX_BURST+1). Counter arithmetic is unsigned with no overflow, because release occurs at MAX_BURST-1.

Decomposition:
- Shared package fifo_pkg holds the state enum (IDLE, GRANT) and the function for the round-robin next-index search. The FIFO parameters stay local.
- One sub-module is natural: rr_pick, a combinational first-set-bit search starting from pointer+1 with wrap. It is reused by any future read-side scheduler.
- Everything else lives in fifo_wr_arbiter.

Test Plan:
- Reset, then only req_valid[2]=1 with 3 words, last on word 3 → grant_id=2 one cycle after valid; 3 consecutive fifo_wr_en pulses; grant_valid=0 after the third.
- All 4 producers continuously valid, no last, MAX_BURST=4 → grants in order 0,1,2,3,0; exactly 4 writes each; one bubble cycle between grants.
- Producer 1 granted, fifo_full=1 for 5 cycles mid-burst after 2 words → req_ready[1]=0 and wr_en=0 during stall; grant held; writes resume and total 4 words.
- Producer 0 granted, drops valid after 1 word → release next edge; producer 3 (also valid) granted next; producer 0 re-raising valid is served after 3.
- Assert rst_n low during the 3rd word of a burst → fifo_wr_en, req_ready, grant_valid go to 0 immediately. After release the first grant goes to producer 0 when 0 and 2 both request.
- Data integrity: producers 0..3 each send tagged words 0xA0000000+i*16+n → FIFO receives each producer's words in order and none are lost or duplicated, checked against a scoreboard.
